// File: rtl/otter_pkg.sv
// ---------------------------------------------------------------------------
// otter_pkg
// Shared constants and types for the OTTER PC sequencer: RV32I opcodes that
// steer the next-PC choice, branch funct3 codes, the mret encoding and the
// sequencer state enum.
// ---------------------------------------------------------------------------
package otter_pkg;

    // Opcodes (ir[6:0]) the sequencer cares about
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;

    // Branch funct3 (ir[14:12]); 010/011 are unused and resolve not-taken
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // Full mret encoding; matched as a whole word, not just by opcode
    localparam logic [31:0] MRET_INSN = 32'h3020_0073;

    typedef enum logic [1:0] {
        ST_FETCH    = 2'd0,
        ST_EXEC     = 2'd1,
        ST_WAIT_MEM = 2'd2,
        ST_TRAP     = 2'd3
    } seq_state_t;

    // True for instructions that may stall on the data memory
    function automatic logic is_mem_op(input logic [6:0] opcode);
        return (opcode == OP_LOAD) || (opcode == OP_STORE);
    endfunction

endpackage

// File: rtl/otter_pc_sequencer_if.sv
// ---------------------------------------------------------------------------
// otter_pc_sequencer_if
// Bundle of every signal between the PC sequencer and its neighbours
// (instruction memory, register file, address generator, CSR unit, data
// memory).
//   master : the sequencer (drives fetch_req, pc, ir_q, status pulses)
//   slave  : the surrounding core / environment
// ---------------------------------------------------------------------------
interface otter_pc_sequencer_if #(
    parameter int XLEN = 32
);
    // instruction fetch
    logic            fetch_req;
    logic            fetch_ack;
    logic [31:0]     ir;
    // operands and targets for ir_q
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic [XLEN-1:0] jal_tgt;
    logic [XLEN-1:0] branch_tgt;
    logic [XLEN-1:0] jalr_tgt;
    // CSR / interrupt / memory status
    logic [XLEN-1:0] mtvec;
    logic [XLEN-1:0] mepc;
    logic            intr;
    logic            mie;
    logic            mem_busy;
    // sequencer outputs
    logic [XLEN-1:0] pc;
    logic [31:0]     ir_q;
    logic            exec_valid;
    logic            redirect;
    logic            trap_take;
    logic [XLEN-1:0] trap_epc;
    logic            misalign;

    modport master (
        output fetch_req, pc, ir_q, exec_valid, redirect, trap_take,
               trap_epc, misalign,
        input  fetch_ack, ir, rs1_val, rs2_val, jal_tgt, branch_tgt,
               jalr_tgt, mtvec, mepc, intr, mie, mem_busy
    );

    modport slave (
        input  fetch_req, pc, ir_q, exec_valid, redirect, trap_take,
               trap_epc, misalign,
        output fetch_ack, ir, rs1_val, rs2_val, jal_tgt, branch_tgt,
               jalr_tgt, mtvec, mepc, intr, mie, mem_busy
    );

endinterface

// File: rtl/otter_branch_cond.sv
// ---------------------------------------------------------------------------
// otter_branch_cond
// Combinational branch resolver: decides taken/not-taken from funct3 and the
// two register operands.
//   funct3_i : ir[14:12] of the branch
//   rs1_i    : first operand
//   rs2_i    : second operand
//   taken_o  : 1 when the branch condition holds
// ---------------------------------------------------------------------------
module otter_branch_cond
    import otter_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    output logic            taken_o
);

    logic eq, lt_s, lt_u;

    assign eq   = (rs1_i == rs2_i);
    assign lt_s = ($signed(rs1_i) < $signed(rs2_i));
    assign lt_u = (rs1_i < rs2_i);

    always_comb begin
        taken_o = 1'b0;
        case (funct3_i)
            F3_BEQ:  taken_o = eq;
            F3_BNE:  taken_o = ~eq;
            F3_BLT:  taken_o = lt_s;
            F3_BGE:  taken_o = ~lt_s;
            F3_BLTU: taken_o = lt_u;
            F3_BGEU: taken_o = ~lt_u;
            default: taken_o = 1'b0;   // reserved encodings: silently not taken
        endcase
    end

endmodule

// File: rtl/otter_pc_sequencer.sv
// ---------------------------------------------------------------------------
// otter_pc_sequencer
// Multicycle PC sequencer for the OTTER RV32I core. Owns the PC, runs the
// FETCH -> EXEC -> (WAIT_MEM) -> (TRAP) -> FETCH loop, resolves branches and
// picks the next PC (pc+4, jal/branch/jalr targets, mepc on mret, mtvec on
// interrupt entry).
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : master side of otter_pc_sequencer_if
//           fetch_req/fetch_ack/ir       instruction fetch handshake
//           rs1_val/rs2_val, *_tgt       operands and targets for ir_q
//           mtvec/mepc/intr/mie          trap vector, return addr, interrupt
//           mem_busy                     load/store of ir_q still in flight
//           pc/ir_q/exec_valid           architectural state
//           redirect/trap_take/misalign  one-cycle event pulses
//           trap_epc                     PC to resume at after the trap
// ---------------------------------------------------------------------------
module otter_pc_sequencer
    import otter_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    otter_pc_sequencer_if.master bus
);

    seq_state_t      state_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] npc_q;       // next PC held across WAIT_MEM
    logic [XLEN-1:0] trap_epc_q;
    logic [31:0]     ir_q;

    logic [6:0]      opcode;
    logic            br_taken;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] npc_d;
    logic            is_redir;
    logic            irq;
    logic            exec_stall;
    logic            exec_done;

    assign opcode = ir_q[6:0];

    otter_branch_cond #(.XLEN(XLEN)) u_branch_cond (
        .funct3_i (ir_q[14:12]),
        .rs1_i    (bus.rs1_val),
        .rs2_i    (bus.rs2_val),
        .taken_o  (br_taken)
    );

    // Next-PC selection for the instruction in ir_q. Addition wraps mod 2^XLEN.
    always_comb begin
        pc_plus4 = pc_q + XLEN'(4);
        npc_d    = pc_plus4;
        is_redir = 1'b0;
        if (ir_q == MRET_INSN) begin
            npc_d    = bus.mepc;
            is_redir = 1'b1;
        end else begin
            case (opcode)
                OP_JAL: begin
                    npc_d    = bus.jal_tgt;
                    is_redir = 1'b1;
                end
                OP_JALR: begin
                    npc_d    = bus.jalr_tgt & {{(XLEN-1){1'b1}}, 1'b0};
                    is_redir = 1'b1;
                end
                OP_BRANCH: begin
                    if (br_taken) begin
                        npc_d    = bus.branch_tgt;
                        is_redir = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign irq        = bus.intr & bus.mie;
    assign exec_stall = (state_q == ST_EXEC) && is_mem_op(opcode) && bus.mem_busy;
    assign exec_done  = (state_q == ST_EXEC) && !exec_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_FETCH;
            pc_q       <= RESET_PC;
            npc_q      <= '0;
            trap_epc_q <= '0;
            ir_q       <= '0;
        end else begin
            case (state_q)
                ST_FETCH: begin
                    if (bus.fetch_ack) begin
                        ir_q    <= bus.ir;
                        state_q <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (exec_stall) begin
                        // pc stays on the load/store until memory finishes
                        npc_q   <= npc_d;
                        state_q <= ST_WAIT_MEM;
                    end else if (irq) begin
                        trap_epc_q <= npc_d;
                        state_q    <= ST_TRAP;
                    end else begin
                        pc_q    <= npc_d;
                        state_q <= ST_FETCH;
                    end
                end
                ST_WAIT_MEM: begin
                    if (!bus.mem_busy) begin
                        if (irq) begin
                            trap_epc_q <= npc_q;
                            state_q    <= ST_TRAP;
                        end else begin
                            pc_q    <= npc_q;
                            state_q <= ST_FETCH;
                        end
                    end
                end
                ST_TRAP: begin
                    pc_q    <= bus.mtvec;
                    state_q <= ST_FETCH;
                end
                default: state_q <= ST_FETCH;
            endcase
        end
    end

    // Pulses are decoded from the current state, so they drop to 0 the
    // instant reset asserts (state is forced to FETCH). redirect only fires
    // when pc is actually written from a jump target; an instruction that is
    // pre-empted by an interrupt hands its target to trap_epc instead.
    // Loads/stores never redirect, so WAIT_MEM completion needs no pulse.
    assign bus.fetch_req  = (state_q == ST_FETCH) && rst_n;
    assign bus.exec_valid = (state_q == ST_EXEC);
    assign bus.redirect   = exec_done && !irq && is_redir;
    assign bus.misalign   = exec_done && !irq && is_redir && (npc_d[1:0] != 2'b00);
    assign bus.trap_take  = (state_q == ST_TRAP);
    assign bus.pc         = pc_q;
    assign bus.ir_q       = ir_q;
    assign bus.trap_epc   = trap_epc_q;

endmodule

// File: tb/tb_otter_pc_sequencer.sv
// ---------------------------------------------------------------------------
// tb_otter_pc_sequencer
// Self-checking bench for otter_pc_sequencer (RESET_PC = 0x100). Inputs are
// driven 1 time unit after the falling edge; a monitor samples outputs 3
// units after the falling edge and keeps running pulse/cycle totals.
// Expected per-instruction results are queued before each instruction is
// issued and popped when it completes.
// ---------------------------------------------------------------------------
module tb_otter_pc_sequencer;

    localparam logic [31:0] ADDI = 32'h0000_0013;
    localparam logic [31:0] JAL  = 32'h0000_006F;
    localparam logic [31:0] JALR = 32'h0000_0067;
    localparam logic [31:0] BEQ  = 32'h0000_0063;
    localparam logic [31:0] BNE  = 32'h0000_1063;
    localparam logic [31:0] BF3R = 32'h0000_2063;   // reserved funct3 010
    localparam logic [31:0] BLT  = 32'h0000_4063;
    localparam logic [31:0] BGE  = 32'h0000_5063;
    localparam logic [31:0] BLTU = 32'h0000_6063;
    localparam logic [31:0] BGEU = 32'h0000_7063;
    localparam logic [31:0] MRET = 32'h3020_0073;
    localparam logic [31:0] SW   = 32'h0000_2023;
    localparam logic [31:0] LW   = 32'h0000_2003;

    typedef struct {
        logic [31:0] pc;
        int          red;
        int          mis;
        int          trap;
        logic [31:0] epc;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    otter_pc_sequencer_if #(.XLEN(32)) bus();

    otter_pc_sequencer #(.XLEN(32), .RESET_PC(32'h0000_0100)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // monitor running totals
    int          mon_red = 0, mon_mis = 0, mon_trap = 0, mon_exec = 0, mon_cyc = 0;
    logic [31:0] mon_epc = '0;

    always begin
        @(negedge clk);
        #3;
        mon_cyc = mon_cyc + 1;
        if (bus.redirect)   mon_red  = mon_red + 1;
        if (bus.misalign)   mon_mis  = mon_mis + 1;
        if (bus.exec_valid) mon_exec = mon_exec + 1;
        if (bus.trap_take) begin
            mon_trap = mon_trap + 1;
            mon_epc  = bus.trap_epc;
        end
    end

    // observations from the last run_insn
    logic [31:0] o_pc, o_epc;
    int          o_red, o_mis, o_trap, o_exec, o_cyc;
    bit          o_to;

    task automatic set_targets(input logic [31:0] t);
        bus.jal_tgt    = t;
        bus.branch_tgt = t;
        bus.jalr_tgt   = t;
        bus.mepc       = t;
    endtask

    // Issue one instruction from FETCH and run it back to the next FETCH.
    // busy: cycles mem_busy stays high starting in EXEC.
    // irq_mode: 0 none, 1 raise in WAIT_MEM and hold, 2 raise then drop
    // before completion, 3 raise in EXEC.
    task automatic run_insn(input logic [31:0] insn, input int busy, input int irq_mode);
        int n;
        int s_red, s_mis, s_trap, s_exec, s_cyc;
        o_to = 1'b0; o_pc = '0; o_epc = '0;
        o_red = 0; o_mis = 0; o_trap = 0; o_exec = 0; o_cyc = 0;
        n = 0;
        while (!bus.fetch_req && n < 20) begin
            @(negedge clk); #1; n++;
        end
        if (!bus.fetch_req) begin
            o_to = 1'b1;
            return;
        end
        s_red = mon_red; s_mis = mon_mis; s_trap = mon_trap;
        s_exec = mon_exec; s_cyc = mon_cyc;
        bus.ir        = insn;
        bus.fetch_ack = 1'b1;
        bus.mem_busy  = (busy > 0);
        @(negedge clk); #1;                 // EXEC
        bus.fetch_ack = 1'b0;
        bus.ir        = '0;
        bus.intr      = (irq_mode == 3);
        for (int i = 1; i < busy; i++) begin
            @(negedge clk); #1;             // WAIT_MEM, still busy
            if (i == 1 && (irq_mode == 1 || irq_mode == 2)) bus.intr = 1'b1;
            if (i == busy - 1 && irq_mode == 2) bus.intr = 1'b0;
        end
        if (busy > 0) begin
            @(negedge clk); #1;
            bus.mem_busy = 1'b0;
        end
        n = 0;
        do begin
            @(negedge clk); #1; n++;
        end while (!bus.fetch_req && n < 10);
        if (!bus.fetch_req) o_to = 1'b1;
        bus.intr     = 1'b0;
        bus.mem_busy = 1'b0;
        o_pc   = bus.pc;
        o_epc  = mon_epc;
        o_red  = mon_red - s_red;
        o_mis  = mon_mis - s_mis;
        o_trap = mon_trap - s_trap;
        o_exec = mon_exec - s_exec;
        o_cyc  = mon_cyc - s_cyc;
    endtask

    task automatic test_reset;
        exp_t e;
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (bus.pc !== 32'h100) begin n_fail++; $display("FAIL reset_pc: got %h expected %h", bus.pc, 32'h100); end
        n_checks++; if (bus.ir_q !== 32'h0) begin n_fail++; $display("FAIL reset_ir_q: got %h expected 0", bus.ir_q); end
        n_checks++; if (bus.trap_epc !== 32'h0) begin n_fail++; $display("FAIL reset_epc: got %h expected 0", bus.trap_epc); end
        n_checks++; if (bus.fetch_req !== 1'b0) begin n_fail++; $display("FAIL reset_fetch_req: got %b expected 0", bus.fetch_req); end
        n_checks++;
        if ({bus.redirect, bus.trap_take, bus.misalign, bus.exec_valid} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_pulses: got %b expected 0000",
                     {bus.redirect, bus.trap_take, bus.misalign, bus.exec_valid});
        end
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        #1;
        n_checks++; if (bus.fetch_req !== 1'b1) begin n_fail++; $display("FAIL release_fetch_req: got %b expected 1", bus.fetch_req); end
        exp_q.push_back('{pc: 32'h104, red: 0, mis: 0, trap: 0, epc: 32'h0, cyc: 2});
        run_insn(ADDI, 0, 0);
        e = exp_q.pop_front();
        n_checks++; if (o_to) begin n_fail++; $display("FAIL first_addi: timeout got 1 expected 0"); end
        n_checks++; if (o_pc !== e.pc) begin n_fail++; $display("FAIL first_addi pc: got %h expected %h", o_pc, e.pc); end
        n_checks++; if (o_red !== e.red) begin n_fail++; $display("FAIL first_addi redirect: got %0d expected %0d", o_red, e.red); end
        n_checks++; if (o_cyc !== e.cyc) begin n_fail++; $display("FAIL first_addi latency: got %0d expected %0d", o_cyc, e.cyc); end
        n_checks++; if (bus.ir_q !== ADDI) begin n_fail++; $display("FAIL first_addi ir_q: got %h expected %h", bus.ir_q, ADDI); end
    endtask

    task automatic test_branch;
        logic [31:0] ins [7], r1 [7], r2 [7], tg [7], xp [7];
        int          xr [7];
        exp_t        e;
        // starting pc 0x104
        ins = '{BEQ, BNE, BLT, BLTU, BF3R, BGEU, BGE};
        r1  = '{32'd5, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        r2  = '{32'd5, 32'd5, 32'd1, 32'd1, 32'd5, 32'd1, 32'd1};
        tg  = '{32'h200, 32'h280, 32'h300, 32'h380, 32'h500, 32'h400, 32'h600};
        xp  = '{32'h200, 32'h204, 32'h300, 32'h304, 32'h308, 32'h400, 32'h404};
        xr  = '{1, 0, 1, 0, 0, 1, 0};
        for (int i = 0; i < 7; i++) begin
            bus.rs1_val = r1[i];
            bus.rs2_val = r2[i];
            set_targets(tg[i]);
            exp_q.push_back('{pc: xp[i], red: xr[i], mis: 0, trap: 0, epc: 32'h0, cyc: 2});
            run_insn(ins[i], 0, 0);
            e = exp_q.pop_front();
            n_checks++; if (o_to) begin n_fail++; $display("FAIL branch[%0d]: timeout got 1 expected 0", i); end
            n_checks++; if (o_pc !== e.pc) begin n_fail++; $display("FAIL branch[%0d] pc: got %h expected %h", i, o_pc, e.pc); end
            n_checks++; if (o_red !== e.red) begin n_fail++; $display("FAIL branch[%0d] redirect: got %0d expected %0d", i, o_red, e.red); end
            n_checks++; if (o_mis !== e.mis) begin n_fail++; $display("FAIL branch[%0d] misalign: got %0d expected %0d", i, o_mis, e.mis); end
            n_checks++; if (o_cyc !== e.cyc) begin n_fail++; $display("FAIL branch[%0d] latency: got %0d expected %0d", i, o_cyc, e.cyc); end
        end
    endtask

    task automatic test_jump;
        logic [31:0] ins [6], tg [6], xp [6];
        int          xr [6], xm [6];
        exp_t        e;
        // starting pc 0x404; last two rows cover the wrap of pc+4
        ins = '{JAL, JALR, MRET, JAL, JAL, ADDI};
        tg  = '{32'h40, 32'h303, 32'h600, 32'h6, 32'hFFFF_FFFC, 32'h0};
        xp  = '{32'h40, 32'h302, 32'h600, 32'h6, 32'hFFFF_FFFC, 32'h0};
        xr  = '{1, 1, 1, 1, 1, 0};
        xm  = '{0, 1, 0, 1, 0, 0};
        for (int i = 0; i < 6; i++) begin
            set_targets(tg[i]);
            exp_q.push_back('{pc: xp[i], red: xr[i], mis: xm[i], trap: 0, epc: 32'h0, cyc: 2});
            run_insn(ins[i], 0, 0);
            e = exp_q.pop_front();
            n_checks++; if (o_to) begin n_fail++; $display("FAIL jump[%0d]: timeout got 1 expected 0", i); end
            n_checks++; if (o_pc !== e.pc) begin n_fail++; $display("FAIL jump[%0d] pc: got %h expected %h", i, o_pc, e.pc); end
            n_checks++; if (o_red !== e.red) begin n_fail++; $display("FAIL jump[%0d] redirect: got %0d expected %0d", i, o_red, e.red); end
            n_checks++; if (o_mis !== e.mis) begin n_fail++; $display("FAIL jump[%0d] misalign: got %0d expected %0d", i, o_mis, e.mis); end
        end
    endtask

    task automatic test_mem_interrupt;
        logic [31:0] ins [5], xp [5], xe [5];
        int          bz [5], md [5], xt [5], xc [5];
        bit          me [5];
        exp_t        e;
        // starting pc 0x0
        bus.mtvec = 32'h800;
        ins = '{SW, LW, ADDI, ADDI, LW};
        bz  = '{3, 3, 0, 0, 0};
        md  = '{1, 2, 3, 3, 0};
        me  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        xp  = '{32'h800, 32'h804, 32'h808, 32'h800, 32'h804};
        xt  = '{1, 0, 0, 1, 0};
        xe  = '{32'h4, 32'h0, 32'h0, 32'h80C, 32'h0};
        xc  = '{6, 5, 2, 3, 2};
        for (int i = 0; i < 5; i++) begin
            bus.mie = me[i];
            exp_q.push_back('{pc: xp[i], red: 0, mis: 0, trap: xt[i], epc: xe[i], cyc: xc[i]});
            run_insn(ins[i], bz[i], md[i]);
            e = exp_q.pop_front();
            n_checks++; if (o_to) begin n_fail++; $display("FAIL mem_irq[%0d]: timeout got 1 expected 0", i); end
            n_checks++; if (o_pc !== e.pc) begin n_fail++; $display("FAIL mem_irq[%0d] pc: got %h expected %h", i, o_pc, e.pc); end
            n_checks++; if (o_trap !== e.trap) begin n_fail++; $display("FAIL mem_irq[%0d] trap_take: got %0d expected %0d", i, o_trap, e.trap); end
            n_checks++; if (o_red !== e.red) begin n_fail++; $display("FAIL mem_irq[%0d] redirect: got %0d expected %0d", i, o_red, e.red); end
            n_checks++; if (o_cyc !== e.cyc) begin n_fail++; $display("FAIL mem_irq[%0d] latency: got %0d expected %0d", i, o_cyc, e.cyc); end
            if (e.trap != 0) begin
                n_checks++; if (o_epc !== e.epc) begin n_fail++; $display("FAIL mem_irq[%0d] trap_epc: got %h expected %h", i, o_epc, e.epc); end
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] model_pc;
        exp_t        e;
        // starting pc 0x804; queue all expectations up front
        model_pc = 32'h804;
        for (int i = 0; i < 4; i++) begin
            model_pc = model_pc + 32'd4;
            exp_q.push_back('{pc: model_pc, red: 0, mis: 0, trap: 0, epc: 32'h0, cyc: 2});
        end
        for (int i = 0; i < 4; i++) begin
            run_insn(ADDI, 0, 0);
            e = exp_q.pop_front();
            n_checks++; if (o_pc !== e.pc) begin n_fail++; $display("FAIL b2b[%0d] pc: got %h expected %h", i, o_pc, e.pc); end
            n_checks++; if (o_exec !== 1) begin n_fail++; $display("FAIL b2b[%0d] exec_valid cycles: got %0d expected 1", i, o_exec); end
            n_checks++; if (o_cyc !== e.cyc) begin n_fail++; $display("FAIL b2b[%0d] latency: got %0d expected %0d", i, o_cyc, e.cyc); end
        end
    endtask

    task automatic test_reset_mid;
        exp_t e;
        int   s_pulse;
        bus.mie = 1'b0;
        set_targets(32'h40);
        exp_q.push_back('{pc: 32'h40, red: 1, mis: 0, trap: 0, epc: 32'h0, cyc: 2});
        run_insn(JAL, 0, 0);
        e = exp_q.pop_front();
        n_checks++; if (o_pc !== e.pc) begin n_fail++; $display("FAIL rstmid_setup pc: got %h expected %h", o_pc, e.pc); end
        // store that stalls in WAIT_MEM
        bus.ir = SW; bus.fetch_ack = 1'b1; bus.mem_busy = 1'b1;
        @(negedge clk); #1;
        bus.fetch_ack = 1'b0;
        @(negedge clk); #1;
        n_checks++; if (bus.exec_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_wait exec_valid: got %b expected 0", bus.exec_valid); end
        n_checks++; if (bus.pc !== 32'h40) begin n_fail++; $display("FAIL rstmid_wait pc: got %h expected %h", bus.pc, 32'h40); end
        s_pulse = mon_red + mon_mis + mon_trap;
        rst_n = 1'b0;
        #1;
        n_checks++; if (bus.pc !== 32'h100) begin n_fail++; $display("FAIL rstmid pc: got %h expected %h", bus.pc, 32'h100); end
        n_checks++; if (bus.ir_q !== 32'h0) begin n_fail++; $display("FAIL rstmid ir_q: got %h expected 0", bus.ir_q); end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); #1;
            n_checks++; if (bus.fetch_req !== 1'b0) begin n_fail++; $display("FAIL rstmid[%0d] fetch_req: got %b expected 0", i, bus.fetch_req); end
        end
        bus.mem_busy = 1'b0;
        rst_n = 1'b1;
        #1;
        n_checks++; if ((mon_red + mon_mis + mon_trap) !== s_pulse) begin n_fail++; $display("FAIL rstmid pulses: got %0d expected %0d", mon_red + mon_mis + mon_trap, s_pulse); end
        n_checks++; if (bus.fetch_req !== 1'b1) begin n_fail++; $display("FAIL rstmid release fetch_req: got %b expected 1", bus.fetch_req); end
        exp_q.push_back('{pc: 32'h104, red: 0, mis: 0, trap: 0, epc: 32'h0, cyc: 2});
        run_insn(ADDI, 0, 0);
        e = exp_q.pop_front();
        n_checks++; if (o_to) begin n_fail++; $display("FAIL rstmid_restart: timeout got 1 expected 0"); end
        n_checks++; if (o_pc !== e.pc) begin n_fail++; $display("FAIL rstmid_restart pc: got %h expected %h", o_pc, e.pc); end
    endtask

    initial begin
        bus.fetch_ack  = 1'b0;
        bus.ir         = '0;
        bus.rs1_val    = '0;
        bus.rs2_val    = '0;
        bus.jal_tgt    = '0;
        bus.branch_tgt = '0;
        bus.jalr_tgt   = '0;
        bus.mtvec      = '0;
        bus.mepc       = '0;
        bus.intr       = 1'b0;
        bus.mie        = 1'b0;
        bus.mem_busy   = 1'b0;
        test_reset();
        test_branch();
        test_jump();
        test_mem_interrupt();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
